// File: rtl/acl2_mode_sequencer.sv
// Command sequencer for the PMOD ACL2 driver: soft reset, init, start handshakes,
// with ack/done/data timeouts, bounded retries, and restart on mode change or data stall.
module acl2_mode_sequencer #(
    parameter int unsigned parm_fast_simulation = 0,
    parameter int unsigned FCLK                 = 20000000,
    parameter int unsigned parm_ack_timeout     = 64,
    parameter int unsigned parm_done_timeout    = 2**20,
    parameter int unsigned parm_data_timeout    = 2**22,
    parameter int unsigned parm_max_retries     = 3
) (
    input  logic        i_clk_20mhz,
    input  logic        i_rstn_20mhz,
    input  logic        i_enable,
    input  logic        i_mode_sel,
    input  logic        i_command_ready,
    input  logic        i_data_valid,
    output logic        o_cmd_soft_reset_acl2,
    output logic        o_cmd_init_measur_mode,
    output logic        o_cmd_start_measur_mode,
    output logic        o_cmd_init_linked_mode,
    output logic        o_cmd_start_linked_mode,
    output logic        o_running,
    output logic        o_active_mode,
    output logic        o_fault,
    output logic [3:0]  o_retry_count,
    output logic [15:0] o_sample_count,
    output logic [3:0]  o_seq_state
);

    localparam int unsigned STARTUP_CYCLES = (parm_fast_simulation != 0) ? 16 : FCLK / 100;

    typedef enum logic [3:0] {
        ST_STARTUP     = 4'd0,
        ST_IDLE        = 4'd1,
        ST_RST_ISSUE   = 4'd2,
        ST_RST_ACK     = 4'd3,
        ST_RST_DONE    = 4'd4,
        ST_INIT_ISSUE  = 4'd5,
        ST_INIT_ACK    = 4'd6,
        ST_INIT_DONE   = 4'd7,
        ST_START_ISSUE = 4'd8,
        ST_START_ACK   = 4'd9,
        ST_START_DONE  = 4'd10,
        ST_RUN         = 4'd11,
        ST_FAULT       = 4'd12
    } state_t;

    // cmd bit order: {start_linked, init_linked, start_measur, init_measur, soft_reset}
    localparam logic [4:0] CMD_SOFT    = 5'b00001;
    localparam logic [4:0] CMD_INIT_M  = 5'b00010;
    localparam logic [4:0] CMD_START_M = 5'b00100;
    localparam logic [4:0] CMD_INIT_L  = 5'b01000;
    localparam logic [4:0] CMD_START_L = 5'b10000;

    state_t      state, state_nxt;
    logic [31:0] timer;
    logic [4:0]  cmd_q, cmd_nxt;
    logic [3:0]  retry_q, retry_nxt;
    logic [4:0]  retry_inc;
    logic        mode_q, mode_nxt;
    logic        fail;

    always_comb begin
        state_nxt = state;
        cmd_nxt   = '0;
        retry_nxt = retry_q;
        mode_nxt  = mode_q;
        fail      = 1'b0;
        retry_inc = {1'b0, retry_q} + 5'd1;

        case (state)
            ST_STARTUP:
                if (timer >= STARTUP_CYCLES - 1) state_nxt = ST_IDLE;
            ST_IDLE:
                if (i_enable) begin
                    mode_nxt  = i_mode_sel;
                    state_nxt = ST_RST_ISSUE;
                end
            ST_RST_ISSUE:
                if (!i_enable) state_nxt = ST_IDLE;
                else if (i_command_ready) begin
                    cmd_nxt   = CMD_SOFT;
                    state_nxt = ST_RST_ACK;
                end
            ST_INIT_ISSUE:
                if (!i_enable) state_nxt = ST_IDLE;
                else if (i_command_ready) begin
                    cmd_nxt   = mode_q ? CMD_INIT_L : CMD_INIT_M;
                    state_nxt = ST_INIT_ACK;
                end
            ST_START_ISSUE:
                if (!i_enable) state_nxt = ST_IDLE;
                else if (i_command_ready) begin
                    cmd_nxt   = mode_q ? CMD_START_L : CMD_START_M;
                    state_nxt = ST_START_ACK;
                end
            ST_RST_ACK, ST_INIT_ACK, ST_START_ACK:
                if (!i_command_ready) state_nxt = state_t'(state + 4'd1);
                else if (timer >= parm_ack_timeout - 1) fail = 1'b1;
            ST_RST_DONE, ST_INIT_DONE:
                if (i_command_ready) state_nxt = i_enable ? state_t'(state + 4'd1) : ST_IDLE;
                else if (timer >= parm_done_timeout - 1) fail = 1'b1;
            ST_START_DONE:
                if (i_command_ready) state_nxt = ST_RUN;
                else if (timer >= parm_done_timeout - 1) fail = 1'b1;
            ST_RUN:
                if (!i_enable) state_nxt = ST_IDLE;
                else if (i_mode_sel != mode_q) begin
                    mode_nxt  = i_mode_sel;
                    retry_nxt = '0;
                    state_nxt = ST_RST_ISSUE;
                end else if (!mode_q && !i_data_valid && timer >= parm_data_timeout - 1) begin
                    fail = 1'b1;
                end
            ST_FAULT:
                state_nxt = ST_FAULT;
            default:
                state_nxt = ST_STARTUP;
        endcase

        if (fail) begin
            retry_nxt = (retry_q == 4'hF) ? retry_q : retry_inc[3:0];
            if (retry_inc > 5'(parm_max_retries)) state_nxt = ST_FAULT;
            else state_nxt = i_enable ? ST_RST_ISSUE : ST_IDLE;
        end

        if (state_nxt == ST_RUN && state != ST_RUN) retry_nxt = '0;
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state          <= ST_STARTUP;
            timer          <= '0;
            cmd_q          <= '0;
            retry_q        <= '0;
            mode_q         <= 1'b0;
            o_running      <= 1'b0;
            o_fault        <= 1'b0;
            o_sample_count <= '0;
        end else begin
            state     <= state_nxt;
            cmd_q     <= cmd_nxt;
            retry_q   <= retry_nxt;
            mode_q    <= mode_nxt;
            o_running <= (state_nxt == ST_RUN);
            if (state_nxt == ST_FAULT) o_fault <= 1'b1;
            if (state == ST_RUN && i_data_valid) o_sample_count <= o_sample_count + 16'd1;
            // data pulses in RUN reload the watchdog through the shared timer
            if (state_nxt != state || (state == ST_RUN && i_data_valid)) timer <= '0;
            else if (timer != '1) timer <= timer + 32'd1;
        end
    end

    assign o_cmd_soft_reset_acl2   = cmd_q[0];
    assign o_cmd_init_measur_mode  = cmd_q[1];
    assign o_cmd_start_measur_mode = cmd_q[2];
    assign o_cmd_init_linked_mode  = cmd_q[3];
    assign o_cmd_start_linked_mode = cmd_q[4];
    assign o_retry_count           = retry_q;
    assign o_active_mode           = mode_q;
    assign o_seq_state             = state;

endmodule
